instr_fetch_unit: RTL and testbench

Instruction fetch front end. It generates sequential PCs, issues word requests to instruction memory and buffers the in-order responses in a small prefetch FIFO. It then presents 32-bit instructions and their PCs to the control/decode stage over a valid/ready handshake. It is the producer side of the instruction interface that the control-to-ALU path consumes, and it honours PC redirects from branch resolution.

---
 rtl/instr_fetch_unit.sv | 112 +++++++++++
 tb/tb_instr_fetch_unit.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - sequential PC fetch front end with credit-limited prefetch FIFO and redirect flush
module instr_fetch_unit #(
    parameter logic [31:0] PC_RESET   = 32'h0000_1000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   rsp_pc_q, rsp_pc_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] drop_cnt_q, drop_cnt_d;
    logic [31:0]   data_q [FIFO_DEPTH];
    logic [31:0]   pc_q   [FIFO_DEPTH];
    logic [CW:0]   credit_used;
    logic          req_fire;
    logic          push;
    logic          pop;

    // Buffered entries plus in-flight requests never exceed the FIFO size.
    assign credit_used    = {1'b0, count_q} + {1'b0, outstanding_q};
    assign imem_req_valid = reset && (credit_used < (CW+1)'(FIFO_DEPTH)) && !redirect_valid;
    assign imem_addr      = fetch_pc_q;
    assign instr_valid    = (count_q != '0) && !redirect_valid;
    assign instr          = data_q[rd_ptr_q];
    assign instr_pc       = pc_q[rd_ptr_q];

    assign req_fire = imem_req_valid && imem_req_ready;
    assign pop      = instr_valid && instr_ready;
    assign push     = imem_rsp_valid && (drop_cnt_q == '0) && !redirect_valid;

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        rsp_pc_d      = rsp_pc_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        drop_cnt_d    = drop_cnt_q;
        outstanding_d = outstanding_q + CW'(req_fire) - CW'(imem_rsp_valid);
        if (redirect_valid) begin
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
            rsp_pc_d   = {redirect_pc[31:2], 2'b00};
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            // outstanding already includes responses still owed to earlier redirects,
            // so every request left in flight after this cycle becomes a drop.
            drop_cnt_d = outstanding_q - CW'(imem_rsp_valid);
        end else begin
            if (req_fire)
                fetch_pc_d = fetch_pc_q + 32'd4;
            if (imem_rsp_valid && (drop_cnt_q != '0))
                drop_cnt_d = drop_cnt_q - CW'(1);
            if (push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
                rsp_pc_d = rsp_pc_q + 32'd4;
            end
            if (pop)
                rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc_q    <= PC_RESET;
            rsp_pc_q      <= PC_RESET;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                data_q[i] <= '0;
                pc_q[i]   <= '0;
            end
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
            if (push) begin
                data_q[wr_ptr_q] <= imem_rsp_data;
                pc_q[wr_ptr_q]   <= rsp_pc_q;
            end
        end
    end

    push_not_full: assert property (@(posedge clk) disable iff (!reset)
        !(push && (count_q == CW'(FIFO_DEPTH))));

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - randomized scoreboard bench for instr_fetch_unit
module tb_instr_fetch_unit;
    localparam logic [31:0] PC_RESET = 32'h0000_1000;
    localparam int          DEPTH    = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    always #5 clk = ~clk;

    instr_fetch_unit #(.PC_RESET(PC_RESET), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    typedef struct { logic [31:0] pc; logic [31:0] data; } exp_t;
    typedef struct { logic [31:0] addr; int due; } mreq_t;

    exp_t        exp_q[$];
    mreq_t       mem_q[$];
    exp_t        mon_e;
    mreq_t       drv_m;
    logic [31:0] acc_log[$];
    logic [31:0] pop_pc_log[$];
    int          pop_cyc_log[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          accepts = 0;
    int          pops = 0;
    int          first_acc = -1;
    int          first_valid = -1;
    int          p_ready, p_mready, lat_min, lat_max;
    bit          pend_redir = 1'b0;
    logic [31:0] pend_pc;
    logic [31:0] exp_next_pc = PC_RESET;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_1000: return 32'h0030_8800;
            32'h0000_1004: return 32'h0030_8801;
            32'h0000_1008: return 32'h2000_8050;
            32'h0000_100C: return 32'h2200_8050;
            default:       return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic clear_logs();
        accepts = 0;
        pops = 0;
        acc_log.delete();
        pop_pc_log.delete();
        pop_cyc_log.delete();
    endtask

    // One cycle of stimulus: memory model, handshake inputs, request-side scoreboard push.
    task automatic step();
        @(negedge clk);
        cyc++;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            drv_m = mem_q.pop_front();
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(drv_m.addr);
        end
        instr_ready    = (int'($urandom_range(99)) < p_ready);
        imem_req_ready = (int'($urandom_range(99)) < p_mready);
        redirect_valid = pend_redir;
        redirect_pc    = pend_redir ? pend_pc : $urandom;
        pend_redir     = 1'b0;
        #1;
        if (redirect_valid) begin
            chk("no_req_in_redirect", 32'(imem_req_valid), 32'd0);
            chk("no_instr_in_redirect", 32'(instr_valid), 32'd0);
            exp_q.delete();
            exp_next_pc = {redirect_pc[31:2], 2'b00};
        end else if (imem_req_valid && imem_req_ready) begin
            chk("req_addr", imem_addr, exp_next_pc);
            exp_q.push_back('{exp_next_pc, mem_word(exp_next_pc)});
            mem_q.push_back('{imem_addr, cyc + 1 + int'($urandom_range(lat_max, lat_min))});
            acc_log.push_back(imem_addr);
            if (first_acc < 0) first_acc = cyc;
            accepts++;
            exp_next_pc = exp_next_pc + 32'd4;
        end
        chk("credit_bound", 32'((exp_q.size() <= DEPTH) && (mem_q.size() <= DEPTH)), 32'd1);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic redirect_to(input logic [31:0] pc);
        pend_redir = 1'b1;
        pend_pc    = pc;
        step();
    endtask

    // Monitor: pops the expected stream whenever decode consumes an instruction.
    initial forever begin
        @(negedge clk);
        #2;
        if (reset && instr_valid) begin
            if (first_valid < 0) first_valid = cyc;
            if (instr_ready) begin
                pops++;
                pop_pc_log.push_back(instr_pc);
                pop_cyc_log.push_back(cyc);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_instr: got pc %h data %h expected none", instr_pc, instr);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("instr_pc", instr_pc, mon_e.pc);
                    chk("instr_data", instr, mon_e.data);
                end
            end
        end
    end

    initial begin
        reset = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data = '0;
        instr_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        p_ready = 100; p_mready = 100; lat_min = 0; lat_max = 0;

        repeat (3) @(negedge clk);
        #1;
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_instr_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_instr_pc", instr_pc, 32'd0);
        chk("rst_addr", imem_addr, PC_RESET);
        @(negedge clk);
        reset = 1'b1;

        // Startup: 1-cycle memory, decode always ready.
        run(10);
        chk("startup_latency", 32'(first_valid - first_acc), 32'd2);
        chk("startup_pops", 32'(pops >= 4), 32'd1);
        if (pops >= 4) begin
            chk("startup_back_to_back", 32'(pop_cyc_log[3] - pop_cyc_log[0]), 32'd3);
            for (int i = 0; i < 4; i++)
                chk("startup_pc", pop_pc_log[i], PC_RESET + 32'(4 * i));
        end

        // Backpressure: decode stalled, memory always ready.
        clear_logs();
        p_ready = 0;
        redirect_to(PC_RESET);
        run(20);
        chk("bp_accepts", 32'(accepts), 32'd4);
        chk("bp_req_low", 32'(imem_req_valid), 32'd0);
        p_ready = 100;
        run(10);
        chk("bp_resume_seen", 32'(acc_log.size() >= 5), 32'd1);
        if (acc_log.size() >= 5) chk("bp_resume_addr", acc_log[4], 32'h0000_1010);

        // Redirect with two buffered, two in flight, one response landing in the redirect cycle.
        p_ready = 0; p_mready = 0;
        redirect_to(PC_RESET);
        run(3);
        p_mready = 100; lat_min = 2; lat_max = 2;
        run(5);
        clear_logs();
        redirect_to(32'h0000_2000);
        p_ready = 100; lat_min = 0; lat_max = 3;
        run(15);
        chk("redir_first_seen", 32'(pops > 0), 32'd1);
        if (pops > 0) chk("redir_first_pc", pop_pc_log[0], 32'h0000_2000);

        // Misaligned redirect target.
        clear_logs();
        redirect_to(32'h0000_3003);
        run(6);
        chk("misalign_seen", 32'(acc_log.size() > 0), 32'd1);
        if (acc_log.size() > 0) chk("misalign_addr", acc_log[0], 32'h0000_3000);

        // PC wraps past the top of the address space.
        clear_logs();
        redirect_to(32'hFFFF_FFF4);
        run(12);
        chk("wrap_seen", 32'(acc_log.size() >= 4), 32'd1);
        if (acc_log.size() >= 4) chk("wrap_addr", acc_log[3], 32'h0000_0000);

        // Random traffic with occasional redirects.
        p_ready = 70; p_mready = 70; lat_min = 0; lat_max = 5;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(99) < 3) begin
                pend_redir = 1'b1;
                pend_pc = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom;
            end
            step();
        end

        // Asynchronous reset between clock edges.
        #3;
        reset = 1'b0;
        #1;
        chk("arst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("arst_instr_valid", 32'(instr_valid), 32'd0);
        chk("arst_instr", instr, 32'd0);
        chk("arst_instr_pc", instr_pc, 32'd0);
        chk("arst_addr", imem_addr, PC_RESET);
        imem_rsp_valid = 1'b0;
        exp_q.delete();
        mem_q.delete();
        exp_next_pc = PC_RESET;
        clear_logs();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        p_ready = 100; p_mready = 100; lat_min = 0; lat_max = 4;
        run(12);
        chk("arst_restart_seen", 32'(acc_log.size() > 0), 32'd1);
        if (acc_log.size() > 0) chk("arst_restart_addr", acc_log[0], PC_RESET);

        // Drain: no new requests, everything in flight returns and is consumed.
        p_mready = 0;
        run(15);
        chk("drain_req_valid", 32'(imem_req_valid), 32'd1);
        chk("drain_instr_valid", 32'(instr_valid), 32'd0);
        chk("drain_exp_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
